// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b computed LSB first
// through one registered full-adder slice evaluating a + ~b + 1.
module serial_subtractor #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             carryout,
    output logic             overflow,
    output logic             zero
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t           state_q,     state_d;
    logic [WIDTH-1:0] a_sh_q,      a_sh_d;
    logic [WIDTH-1:0] b_sh_q,      b_sh_d;
    logic [WIDTH-1:0] res_q,       res_d;
    logic [CW-1:0]    count_q,     count_d;
    logic             carry_q,     carry_d;
    logic [WIDTH-1:0] diff_q,      diff_d;
    logic             carryout_q,  carryout_d;
    logic             overflow_q,  overflow_d;
    logic             zero_q,      zero_d;
    logic             in_ready_q,  in_ready_d;
    logic             out_valid_q, out_valid_d;

    logic sum_bit_s;
    logic carry_bit_s;

    // Full-adder slice on the current LSBs of the operand shift registers.
    always_comb begin
        sum_bit_s   = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        carry_bit_s = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
    end

    // Next-state and datapath control for IDLE -> SHIFT -> DONE.
    always_comb begin
        state_d     = state_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        res_d       = res_q;
        count_d     = count_q;
        carry_d     = carry_q;
        diff_d      = diff_q;
        carryout_d  = carryout_q;
        overflow_d  = overflow_q;
        zero_d      = zero_q;

        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = ~b;
                    carry_d = 1'b1;
                    count_d = {CW{1'b0}};
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                res_d   = {sum_bit_s, res_q[WIDTH-1:1]};
                a_sh_d  = {1'b0, a_sh_q[WIDTH-1:1]};
                b_sh_d  = {1'b0, b_sh_q[WIDTH-1:1]};
                carry_d = carry_bit_s;
                count_d = count_q + CW'(1);
                if (count_q == LAST_BIT) begin
                    // carry_q is the carry into the MSB on this bit.
                    diff_d     = res_d;
                    carryout_d = carry_bit_s;
                    overflow_d = carry_q ^ carry_bit_s;
                    zero_d     = (res_d == {WIDTH{1'b0}});
                    state_d    = DONE;
                end else begin
                    state_d = SHIFT;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end else begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        in_ready_d  = (state_d == IDLE);
        out_valid_d = (state_d == DONE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            a_sh_q      <= {WIDTH{1'b0}};
            b_sh_q      <= {WIDTH{1'b0}};
            res_q       <= {WIDTH{1'b0}};
            count_q     <= {CW{1'b0}};
            carry_q     <= 1'b0;
            diff_q      <= {WIDTH{1'b0}};
            carryout_q  <= 1'b0;
            overflow_q  <= 1'b0;
            zero_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            res_q       <= res_d;
            count_q     <= count_d;
            carry_q     <= carry_d;
            diff_q      <= diff_d;
            carryout_q  <= carryout_d;
            overflow_q  <= overflow_d;
            zero_q      <= zero_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign diff      = diff_q;
    assign carryout  = carryout_q;
    assign overflow  = overflow_q;
    assign zero      = zero_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed vectors, backpressure,
// mid-operation reset and an exhaustive sweep against an arithmetic model.
module tb_serial_subtractor;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] diff;
    logic         carryout;
    logic         overflow;
    logic         zero;

    int tests = 0;
    int fails = 0;
    logic [6:0] exp_q[$];

    serial_subtractor #(.WIDTH(W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .carryout  (carryout),
        .overflow  (overflow),
        .zero      (zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, got, want);
        end
    endtask

    // {diff, carryout, overflow, zero} from plain integer arithmetic.
    function automatic logic [6:0] model(input logic [W-1:0] x, input logic [W-1:0] y);
        logic [W:0]   s;
        logic [W-1:0] d;
        int           sd;
        logic         ov;
        s  = {1'b0, x} + {1'b0, ~y} + 5'd1;
        d  = s[W-1:0];
        sd = int'($signed(x)) - int'($signed(y));
        ov = (sd > 7) || (sd < -8);
        return {d, s[W], ov, (d == 4'd0)};
    endfunction

    // Result checker: every cycle out_valid is high the outputs must match the oldest job.
    always @(negedge clk) begin
        if (!reset && out_valid) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out_valid", 32'd1, 32'd0);
            end else begin
                check("diff",     {28'd0, diff},   {28'd0, exp_q[0][6:3]});
                check("carryout", {31'd0, carryout}, {31'd0, exp_q[0][2]});
                check("overflow", {31'd0, overflow}, {31'd0, exp_q[0][1]});
                check("zero",     {31'd0, zero},     {31'd0, exp_q[0][0]});
                check("in_ready_in_done", {31'd0, in_ready}, 32'd0);
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic do_op(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input int hold);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("accept_ready", {31'd0, in_ready}, 32'd1);
        a = ta; b = tb_v; in_valid = 1'b1;
        exp_q.push_back(model(ta, tb_v));
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = 4'hF; b = 4'hF;
        n = 0;
        while (!out_valid && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check("latency", n, W);
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            a = 4'(i + 3); b = 4'(i);
            @(posedge clk); #1;
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check("ready_after_accept", {31'd0, in_ready}, 32'd1);
        check("valid_after_accept", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = 4'd0; b = 4'd0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_diff",      {28'd0, diff},      32'd0);
        check("rst_flags",     {29'd0, carryout, overflow, zero}, 32'd0);
        reset = 1'b0;

        // Hand-computed values pinning the model: {diff, carryout, overflow, zero}.
        check("model_5_3",  {25'd0, model(4'b0101, 4'b0011)}, {25'd0, 4'b0010, 3'b100});
        check("model_3_5",  {25'd0, model(4'b0011, 4'b0101)}, {25'd0, 4'b1110, 3'b000});
        check("model_m8_1", {25'd0, model(4'b1000, 4'b0001)}, {25'd0, 4'b0111, 3'b110});
        check("model_7_m1", {25'd0, model(4'b0111, 4'b1111)}, {25'd0, 4'b1000, 3'b010});
        check("model_eq",   {25'd0, model(4'b1010, 4'b1010)}, {25'd0, 4'b0000, 3'b101});
        check("model_0_0",  {25'd0, model(4'b0000, 4'b0000)}, {25'd0, 4'b0000, 3'b101});

        do_op(4'b0101, 4'b0011, 0);
        do_op(4'b0011, 4'b0101, 0);
        do_op(4'b1000, 4'b0001, 0);
        do_op(4'b0111, 4'b1111, 0);
        do_op(4'b1010, 4'b1010, 0);
        do_op(4'b0110, 4'b1000, 3);
        do_op(4'b0001, 4'b0110, 0);

        // Reset during the second SHIFT cycle discards the job.
        @(posedge clk); #1;
        a = 4'b0101; b = 4'b0011; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_in_ready",  {31'd0, in_ready},  32'd1);
        check("midrst_diff",      {28'd0, diff},      32'd0);
        check("midrst_flags",     {29'd0, carryout, overflow, zero}, 32'd0);
        repeat (6) begin
            @(posedge clk); #1;
            check("midrst_no_valid", {31'd0, out_valid}, 32'd0);
        end
        do_op(4'b0000, 4'b0000, 0);

        for (int i = 0; i < 16; i++) begin
            for (int j = 0; j < 16; j++) begin
                do_op(4'(i), 4'(j), 0);
            end
        end

        check("queue_drained", exp_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
